stepper_move_scheduler: RTL and testbench
=========================================

STEPPER_MOVE_SCHEDULER -- requirements
Module: stepper_move_scheduler

Interface
REQ-001 Parameter HALF_PERIOD, default 25000: clocks per pulse half-period (1 kHz step rate at 50 MHz).
REQ-002 Parameter DIR_SETUP, default 500: clocks dir is held stable before the first pulse of a move.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 po_data  input  8  received UART byte, valid only when rx_down=1.
REQ-006 rx_down  input  1  one-cycle strobe marking a new po_data byte.
REQ-007 pul_ss, dir_ss  output  1 each  step pulse and direction, axis SS (axis bit 0).
REQ-008 pul_sj, dir_sj  output  1 each  step pulse and direction, axis SJ (axis bit 1).
REQ-009 busy  output  1  high while any axis move is in SETUP, HIGH, LOW or DONE.
REQ-010 done  output  1  one-cycle pulse when a move completes normally.

Function
REQ-011 Parser SHALL accept 3-byte commands: 0xA5 header; byte1 = {axis[7], dir[6], count[13:8]}; byte2 = count[7:0].
REQ-012 Parser, when waiting for a header, SHALL treat 0x5A as STOP and ignore every other non-0xA5 byte.
REQ-013 Bytes 1 and 2 SHALL be taken verbatim, with no header or STOP decode in those positions.
REQ-014 A complete command SHALL load the pending slot of its axis (dir, count) and overwrite any earlier pending command for that axis.
REQ-015 Each axis SHALL have one pending slot; a running move SHALL NOT be altered by a new command for the same axis.
REQ-016 One shared pulse engine SHALL serve the axes, with exactly one axis moving at a time.
REQ-017 In IDLE with one slot pending, that slot SHALL be granted.
REQ-018 In IDLE with both slots pending, the axis not served last SHALL be granted; after reset SS has priority.
REQ-019 FSM states: IDLE, SETUP, HIGH, LOW, DONE.
REQ-020 Grant SHALL clear the slot, drive the granted dir output and enter SETUP.
REQ-021 SETUP SHALL last DIR_SETUP cycles with pul low.
REQ-022 HIGH SHALL hold the granted pul output high for the half-period.
REQ-023 LOW SHALL hold the granted pul output low for the half-period, then decrement the remaining count.
REQ-024 After LOW, remaining=0 SHALL enter DONE; otherwise the FSM SHALL return to HIGH.
REQ-025 DONE SHALL last 1 cycle with done=1, then enter IDLE.
REQ-026 A granted count of 0 SHALL skip SETUP, HIGH and LOW and go directly to DONE (done pulse, no pul edge).
REQ-027 The pul output of the non-granted axis SHALL be 0.
REQ-028 Each dir output SHALL hold its last driven value between moves.
REQ-029 STOP SHALL clear both pending slots.
REQ-030 STOP SHALL force both pul outputs low on the next cycle and enter IDLE without a done pulse; dir outputs are unchanged.
REQ-031 STOP SHALL have no effect when the engine is already idle.
REQ-032 A command completing in the same cycle the engine reaches IDLE SHALL be eligible for grant on the following cycle.
REQ-033 Counters SHALL be 14-bit for steps and 32-bit for timing, with no wrap; maximum move is 16383 steps.

Reset
REQ-034 With rst_n=0, all outputs (pul_ss, dir_ss, pul_sj, dir_sj, busy, done) SHALL be 0.
REQ-035 With rst_n=0, the parser SHALL wait for a header, the FSM SHALL be IDLE, slots SHALL be empty and the round-robin pointer SHALL favour SS.
REQ-036 Reset asserted mid-move SHALL abort the move immediately with no done pulse.

Configuration
REQ-037 Macro STEPPER_RAMP_EN defined: pulses with index <4 from move start, or with remaining count <=4, SHALL use half-period 2*HALF_PERIOD; all other pulses SHALL use HALF_PERIOD.
REQ-038 STEPPER_RAMP_EN undefined: every pulse SHALL use HALF_PERIOD.

Verification (HALF_PERIOD=4, DIR_SETUP=2)
REQ-039 Bytes A5,40,03 -> dir_ss=1; after 2 cycles, 3 pul_ss pulses each 4 high/4 low; done pulses once; pul_sj stays 0.
REQ-040 Bytes A5,80,02 followed immediately by A5,00,02 -> SJ moves first, then SS; busy stays high throughout; two done pulses.
REQ-041 Bytes A5,00,00 -> done one cycle after grant; no pul edges.
REQ-042 Bytes A5,00,0A then 5A after the 2nd pulse -> pul_ss low next cycle; no done pulse; busy=0.
REQ-043 With STEPPER_RAMP_EN defined, bytes A5,00,0A -> pulses 1-4 and 7-10 have 8-cycle halves; pulses 5-6 have 4-cycle halves.
REQ-044 rst_n pulsed low mid-HIGH -> all outputs 0 asynchronously; a new command after release runs normally.

Source files
------------

// File: rtl/stepper_move_scheduler.sv
// stepper_move_scheduler
// Decodes 3-byte UART move commands into one pending slot per axis (SS, SJ)
// and runs them one at a time on a shared step/dir pulse engine. Two pending
// slots are served round-robin.
// Build option: define STEPPER_RAMP_EN to run the first four pulses of a move,
// and the pulses with four or fewer steps remaining, at twice HALF_PERIOD.
// Requires DIR_SETUP >= 1 and HALF_PERIOD >= 1.
//
// state  | meaning
// IDLE   | no move running; grants a pending slot
// SETUP  | dir driven, pul low, waiting DIR_SETUP clocks
// HIGH   | granted pul high for one half-period
// LOW    | granted pul low for one half-period, then count decremented
// DONE   | one-cycle done pulse
module stepper_move_scheduler #(
  parameter int unsigned HALF_PERIOD = 25000,
  parameter int unsigned DIR_SETUP   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] po_data,
  input  logic       rx_down,
  output logic       pul_ss,
  output logic       dir_ss,
  output logic       pul_sj,
  output logic       dir_sj,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0]  HDR_BYTE  = 8'hA5;
  localparam logic [7:0]  STOP_BYTE = 8'h5A;
  localparam logic [31:0] HALF_M1   = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] SETUP_M1  = 32'(DIR_SETUP - 1);

  typedef enum logic [1:0] {P_HDR, P_B1, P_B2} parse_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

  parse_t      parse_q, parse_d;
  logic [7:0]  b1_q, b1_d;
  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [13:0] rem_q, rem_d;
  logic        axis_q, axis_d;
  logic        last_sj_q, last_sj_d;
  logic        dir_ss_q, dir_ss_d, dir_sj_q, dir_sj_d;
  logic        pend_ss_q, pend_ss_d, pend_sj_q, pend_sj_d;
  logic        pdir_ss_q, pdir_ss_d, pdir_sj_q, pdir_sj_d;
  logic [13:0] cnt_ss_q, cnt_ss_d, cnt_sj_q, cnt_sj_d;

  logic        stop, cmd_vld, any_pend, gnt_sj, grant;
  logic [13:0] gnt_cnt;
  logic [31:0] half_cur_m1, half_nxt_m1;

`ifdef STEPPER_RAMP_EN
  localparam logic [31:0] SLOW_M1 = 32'(2 * HALF_PERIOD - 1);
  logic [2:0] idx_q, idx_d, idx_nxt;
  logic [13:0] rem_nxt;
  // idx saturates at 4: only "first four pulses" matters for the ramp
  assign idx_nxt     = (idx_q == 3'd4) ? 3'd4 : idx_q + 3'd1;
  assign rem_nxt     = rem_q - 14'd1;
  assign half_cur_m1 = ((idx_q < 3'd4) || (rem_q <= 14'd4)) ? SLOW_M1 : HALF_M1;
  assign half_nxt_m1 = ((idx_nxt < 3'd4) || (rem_nxt <= 14'd4)) ? SLOW_M1 : HALF_M1;
`else
  assign half_cur_m1 = HALF_M1;
  assign half_nxt_m1 = HALF_M1;
`endif

  assign any_pend = pend_ss_q | pend_sj_q;
  // with both pending, serve the axis not served last
  assign gnt_sj   = pend_sj_q & (~pend_ss_q | ~last_sj_q);
  assign grant    = (state_q == S_IDLE) & any_pend;
  assign gnt_cnt  = gnt_sj ? cnt_sj_q : cnt_ss_q;

  // byte parser: header/STOP decode only in header position
  always_comb begin
    parse_d = parse_q;
    b1_d    = b1_q;
    stop    = 1'b0;
    cmd_vld = 1'b0;
    if (rx_down) begin
      case (parse_q)
        P_HDR: begin
          if (po_data == HDR_BYTE) parse_d = P_B1;
          else if (po_data == STOP_BYTE) stop = 1'b1;
        end
        P_B1: begin
          b1_d    = po_data;
          parse_d = P_B2;
        end
        default: begin
          cmd_vld = 1'b1;
          parse_d = P_HDR;
        end
      endcase
    end
  end

  // pending slots: a new command wins over a same-cycle grant clear
  always_comb begin
    pend_ss_d = pend_ss_q;
    pend_sj_d = pend_sj_q;
    pdir_ss_d = pdir_ss_q;
    pdir_sj_d = pdir_sj_q;
    cnt_ss_d  = cnt_ss_q;
    cnt_sj_d  = cnt_sj_q;
    if (grant && !gnt_sj) pend_ss_d = 1'b0;
    if (grant && gnt_sj) pend_sj_d = 1'b0;
    if (stop) begin
      pend_ss_d = 1'b0;
      pend_sj_d = 1'b0;
    end
    if (cmd_vld) begin
      if (b1_q[7]) begin
        pend_sj_d = 1'b1;
        pdir_sj_d = b1_q[6];
        cnt_sj_d  = {b1_q[5:0], po_data};
      end else begin
        pend_ss_d = 1'b1;
        pdir_ss_d = b1_q[6];
        cnt_ss_d  = {b1_q[5:0], po_data};
      end
    end
  end

  // pulse engine next state; timer is a down-counter ending at zero
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    rem_d     = rem_q;
    axis_d    = axis_q;
    last_sj_d = last_sj_q;
    dir_ss_d  = dir_ss_q;
    dir_sj_d  = dir_sj_q;
`ifdef STEPPER_RAMP_EN
    idx_d     = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          axis_d    = gnt_sj;
          last_sj_d = gnt_sj;
          rem_d     = gnt_cnt;
          tmr_d     = SETUP_M1;
`ifdef STEPPER_RAMP_EN
          idx_d     = 3'd0;
`endif
          if (gnt_sj) dir_sj_d = pdir_sj_q;
          else dir_ss_d = pdir_ss_q;
          state_d = (gnt_cnt == 14'd0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_HIGH;
          tmr_d   = half_cur_m1;
        end else tmr_d = tmr_q - 32'd1;
      end
      S_HIGH: begin
        if (tmr_q == '0) begin
          state_d = S_LOW;
          tmr_d   = half_cur_m1;
        end else tmr_d = tmr_q - 32'd1;
      end
      S_LOW: begin
        if (tmr_q == '0) begin
          rem_d = rem_q - 14'd1;
`ifdef STEPPER_RAMP_EN
          idx_d = idx_nxt;
`endif
          if (rem_q == 14'd1) state_d = S_DONE;
          else begin
            state_d = S_HIGH;
            tmr_d   = half_nxt_m1;
          end
        end else tmr_d = tmr_q - 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE) state_d = S_IDLE;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parse_q   <= P_HDR;
      b1_q      <= '0;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      rem_q     <= '0;
      axis_q    <= 1'b0;
      last_sj_q <= 1'b1;
      dir_ss_q  <= 1'b0;
      dir_sj_q  <= 1'b0;
      pend_ss_q <= 1'b0;
      pend_sj_q <= 1'b0;
      pdir_ss_q <= 1'b0;
      pdir_sj_q <= 1'b0;
      cnt_ss_q  <= '0;
      cnt_sj_q  <= '0;
`ifdef STEPPER_RAMP_EN
      idx_q     <= '0;
`endif
    end else begin
      parse_q   <= parse_d;
      b1_q      <= b1_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      rem_q     <= rem_d;
      axis_q    <= axis_d;
      last_sj_q <= last_sj_d;
      dir_ss_q  <= dir_ss_d;
      dir_sj_q  <= dir_sj_d;
      pend_ss_q <= pend_ss_d;
      pend_sj_q <= pend_sj_d;
      pdir_ss_q <= pdir_ss_d;
      pdir_sj_q <= pdir_sj_d;
      cnt_ss_q  <= cnt_ss_d;
      cnt_sj_q  <= cnt_sj_d;
`ifdef STEPPER_RAMP_EN
      idx_q     <= idx_d;
`endif
    end
  end

  assign pul_ss = (state_q == S_HIGH) & ~axis_q;
  assign pul_sj = (state_q == S_HIGH) & axis_q;
  assign dir_ss = dir_ss_q;
  assign dir_sj = dir_sj_q;
  // a pending slot counts as busy so back-to-back moves show no gap
  assign busy   = (state_q != S_IDLE) | any_pend;
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Bench for stepper_move_scheduler: directed cases plus randomized command
// batches, checked against a move-list model (slot overwrite, round-robin
// order, per-pulse half-period rule).
module tb_stepper_move_scheduler;
  localparam int HP = 4;
  localparam int DS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] po_data = 8'h00;
  logic rx_down = 1'b0;
  logic pul_ss, dir_ss, pul_sj, dir_sj, busy, done;

  stepper_move_scheduler #(.HALF_PERIOD(HP), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst_n(rst_n), .po_data(po_data), .rx_down(rx_down),
    .pul_ss(pul_ss), .dir_ss(dir_ss), .pul_sj(pul_sj), .dir_sj(dir_sj),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int axis; int dir; int n;} mv_t;
  typedef struct {int axis; int dir; int hi; int gap; int cyc;} pl_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // monitor: records every completed pulse with its widths
  pl_t pq[$];
  pl_t cur;
  int done_cnt = 0, last_done_cyc = 0, both_hi = 0;
  int prev_p = 0, hi_run = 0, lo_run = 0, have_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_p = 0;
      have_prev = 0;
    end else begin
      if (pul_ss && pul_sj) both_hi++;
      if ((pul_ss || pul_sj) && prev_p == 0) begin
        cur.axis = int'(pul_sj);
        cur.dir  = pul_sj ? int'(dir_sj) : int'(dir_ss);
        cur.gap  = have_prev ? lo_run : -1;
        cur.cyc  = cyc;
        hi_run = 1;
      end else if (pul_ss || pul_sj) hi_run++;
      else if (prev_p != 0) begin
        cur.hi = hi_run;
        pq.push_back(cur);
        lo_run = 1;
        have_prev = 1;
      end else lo_run++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_p = (pul_ss || pul_sj) ? 1 : 0;
    end
  end

  // reference: half-period of pulse i (0-based) in an n-step move
  function automatic int exp_half(input int i, input int n);
`ifdef STEPPER_RAMP_EN
    return (i < 4 || n - i <= 4) ? 2 * HP : HP;
`else
    return HP;
`endif
  endfunction

  function automatic mv_t mv(input int a, input int d, input int n);
    mv_t m;
    m.axis = a; m.dir = d; m.n = n;
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int last_cyc = 0;
  task automatic send_byte(input logic [7:0] b);
    po_data = b;
    rx_down = 1'b1;
    tick();
    rx_down = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_cmd(input int a, input int d, input int n);
    logic [13:0] c;
    c = 14'(n);
    send_byte(8'hA5);
    send_byte({a[0], d[0], c[13:8]});
    send_byte(c[7:0]);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 4 && k < budget) begin
      tick();
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_reached", 32'(quiet >= 4), 1);
  endtask

  task automatic wait_pul_ss(input int budget);
    int k = 0;
    while (!pul_ss && k < budget) begin
      tick();
      k++;
    end
    check("pul_ss_seen", 32'(pul_ss), 1);
  endtask

  task automatic verify(input mv_t exp[$], input int d0, input int lat_ref);
    pl_t p;
    check("done_count", done_cnt - d0, exp.size());
    foreach (exp[k]) begin
      for (int i = 0; i < exp[k].n; i++) begin
        if (pq.size() == 0) begin
          check("pulse_present", 0, 1);
          break;
        end
        p = pq.pop_front();
        check("pul_axis", p.axis, exp[k].axis);
        check("pul_dir", p.dir, exp[k].dir);
        check("hi_width", p.hi, exp_half(i, exp[k].n));
        if (i > 0) check("lo_width", p.gap, exp_half(i - 1, exp[k].n));
        if (k == 0 && i == 0 && lat_ref >= 0) check("setup_latency", p.cyc - lat_ref, DS + 1);
      end
    end
    check("extra_pulses", pq.size(), 0);
    pq.delete();
  endtask

  initial begin
    mv_t e[$];
    int d0, lat, gaps, k, dpre;
    int has[2];
    int cd[2];
    int cn[2];
    int a0, ax, dr, nb;
    logic [7:0] jb;

    repeat (3) tick();
    check("rst_pul_ss", 32'(pul_ss), 0);
    check("rst_pul_sj", 32'(pul_sj), 0);
    check("rst_dir_ss", 32'(dir_ss), 0);
    check("rst_dir_sj", 32'(dir_sj), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // three steps on SS with dir=1
    d0 = done_cnt;
    send_cmd(0, 1, 3);
    lat = last_cyc;
    wait_idle(2000);
    e.delete(); e.push_back(mv(0, 1, 3));
    verify(e, d0, lat);
    check("dir_ss_hold", 32'(dir_ss), 1);
    check("pul_sj_idle", 32'(pul_sj), 0);

    // zero-count move: done one cycle after grant, no pulses
    d0 = done_cnt;
    send_cmd(0, 0, 0);
    lat = last_cyc;
    wait_idle(200);
    check("zero_done_lat", last_done_cyc - lat, 1);
    e.delete(); e.push_back(mv(0, 0, 0));
    verify(e, d0, -1);
    check("zero_dir_ss", 32'(dir_ss), 0);

    // SJ then SS back to back, busy never drops
    d0 = done_cnt;
    send_cmd(1, 0, 2);
    send_cmd(0, 0, 2);
    gaps = 0; k = 0;
    while (done_cnt - d0 < 2 && k < 2000) begin
      tick();
      k++;
      if (!busy && done_cnt - d0 < 2) gaps++;
    end
    check("b2b_busy_gap", gaps, 0);
    wait_idle(500);
    e.delete(); e.push_back(mv(1, 0, 2)); e.push_back(mv(0, 0, 2));
    verify(e, d0, -1);

    // full 10-step move (ramp shape when enabled)
    d0 = done_cnt;
    send_cmd(0, 0, 10);
    wait_idle(3000);
    e.delete(); e.push_back(mv(0, 0, 10));
    verify(e, d0, -1);

    // STOP mid-move, with a pending SJ command that must be dropped
    d0 = done_cnt;
    send_cmd(0, 0, 10);
    k = 0;
    while (pq.size() < 2 && k < 2000) begin
      tick();
      k++;
    end
    send_cmd(1, 1, 3);
    wait_pul_ss(200);
    send_byte(8'h5A);
    check("stop_pul_low", 32'(pul_ss), 0);
    check("stop_busy", 32'(busy), 0);
    gaps = 0;
    repeat (80) begin
      tick();
      if (busy) gaps++;
    end
    check("stop_stays_idle", gaps, 0);
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_pulses", pq.size(), 3);
    check("stop_dir_ss", 32'(dir_ss), 0);
    check("stop_dir_sj", 32'(dir_sj), 0);
    pq.delete();

    // STOP while idle does nothing; next command runs normally
    send_byte(8'h5A);
    repeat (3) tick();
    check("idle_stop_busy", 32'(busy), 0);
    d0 = done_cnt;
    send_cmd(0, 1, 2);
    wait_idle(1000);
    e.delete(); e.push_back(mv(0, 1, 2));
    verify(e, d0, -1);

    // junk before header, 0x5A taken verbatim as count byte
    d0 = done_cnt;
    send_byte(8'h11);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h5A);
    wait_idle(5000);
    e.delete(); e.push_back(mv(0, 0, 90));
    verify(e, d0, -1);

    // asynchronous reset in the middle of a high phase
    dpre = done_cnt;
    send_cmd(0, 0, 5);
    wait_pul_ss(200);
    rst_n = 1'b0;
    #1;
    check("arst_pul_ss", 32'(pul_ss), 0);
    check("arst_dir_ss", 32'(dir_ss), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_done", done_cnt - dpre, 0);
    pq.delete();
    d0 = done_cnt;
    send_cmd(1, 1, 2);
    wait_idle(1000);
    e.delete(); e.push_back(mv(1, 1, 2));
    verify(e, d0, -1);
    check("arst_dir_sj", 32'(dir_sj), 1);

    // randomized: a long move, then a batch of commands queued behind it
    for (int r = 0; r < 16; r++) begin
      d0 = done_cnt;
      a0 = $urandom_range(0, 1);
      dr = $urandom_range(0, 1);
      e.delete();
      e.push_back(mv(a0, dr, $urandom_range(30, 50)));
      send_cmd(e[0].axis, e[0].dir, e[0].n);
      has[0] = 0; has[1] = 0;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        for (int j = $urandom_range(0, 2); j > 0; j--) begin
          do jb = 8'($urandom_range(0, 255)); while (jb == 8'hA5 || jb == 8'h5A);
          send_byte(jb);
        end
        ax = $urandom_range(0, 1);
        has[ax] = 1;
        cd[ax] = $urandom_range(0, 1);
        cn[ax] = $urandom_range(1, 12);
        send_cmd(ax, cd[ax], cn[ax]);
        repeat ($urandom_range(0, 3)) tick();
      end
      if (has[0] != 0 && has[1] != 0) begin
        e.push_back(mv(1 - a0, cd[1 - a0], cn[1 - a0]));
        e.push_back(mv(a0, cd[a0], cn[a0]));
      end else begin
        ax = (has[1] != 0) ? 1 : 0;
        e.push_back(mv(ax, cd[ax], cn[ax]));
      end
      wait_idle(6000);
      verify(e, d0, -1);
    end

    check("both_pul_high", both_hi, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
